// File: rtl/li_fifo_pkg.sv
// li_fifo shared constants and helpers.
// Read modes, almost-full threshold, config checks.
package li_fifo_pkg;

  localparam int SHOWAHEAD_OFF = 0;
  localparam int SHOWAHEAD_ON  = 1;

  function automatic int af_threshold(
    input int depth,
    input int rl
  );
    return depth - rl;
  endfunction

  function automatic bit addr_ok(input int addr);
    return addr >= 1;
  endfunction

  function automatic bit rl_ok(
    input int addr,
    input int rl
  );
    return (rl >= 1) && (rl <= (1 << addr) - 1);
  endfunction

endpackage

// File: rtl/li_fifo_if.sv
// li_fifo channel bundle.
// slave = fifo side, master = user side.
interface li_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_ADDR  = 5
);
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         i_enq;
  logic                         i_deq;
  logic signed [DATA_WIDTH-1:0] o_data;
  logic                         o_empty;
  logic                         o_full;
  logic                         o_almost_full;
  logic [FIFO_ADDR:0]           o_usedw;
  logic                         o_overflow;
  logic                         o_underflow;

  modport slave (
    input  i_data, i_enq, i_deq,
    output o_data, o_empty, o_full,
    output o_almost_full, o_usedw,
    output o_overflow, o_underflow
  );

  modport master (
    output i_data, i_enq, i_deq,
    input  o_data, o_empty, o_full,
    input  o_almost_full, o_usedw,
    input  o_overflow, o_underflow
  );
endinterface

// File: rtl/li_fifo_ram.sv
// li_fifo storage: simple dual-port RAM.
// One write port, one registered read port.
module li_fifo_ram #(
  parameter int    DW       = 32,
  parameter int    AW       = 5,
  parameter string RAMSTYLE = "MLAB"
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  (* ramstyle = RAMSTYLE *)
  logic [DW-1:0] mem [2**AW];

  // write port and registered read port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/li_fifo.sv
// li_fifo: LI channel FIFO with backpressure.
// Show-ahead uses a RAM-out stage plus prefetch reg.
module li_fifo
  import li_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    FIFO_ADDR     = 5,
  parameter int    READY_LATENCY = 4,
  parameter int    SHOWAHEAD     = 1,
  parameter string RAMSTYLE      = "MLAB"
) (
  input logic    clock,
  input logic    reset,
  li_fifo_if.slave ch
);

  localparam int DEPTH = 2**FIFO_ADDR;
  localparam int AF = af_threshold(DEPTH, READY_LATENCY);
  localparam bit SA = (SHOWAHEAD == SHOWAHEAD_ON);

  typedef logic [FIFO_ADDR:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF);

  if (!addr_ok(FIFO_ADDR)) begin : g_bad_addr
    $error("li_fifo: FIFO_ADDR must be >= 1");
  end
  if (!rl_ok(FIFO_ADDR, READY_LATENCY)) begin : g_bad_rl
    $error("li_fifo: READY_LATENCY out of range");
  end
  if (RAMSTYLE != "MLAB" && RAMSTYLE != "M20K") begin : g_bad_rs
    $error("li_fifo: RAMSTYLE must be MLAB or M20K");
  end

  logic [FIFO_ADDR-1:0]  wr_ptr, rd_ptr;
  cnt_t                  usedw, ram_cnt;
  cnt_t                  usedw_n, ram_cnt_n;
  logic                  q_valid, pf_valid;
  logic                  q_valid_n, pf_valid_n;
  logic                  ovf, unf;
  logic [DATA_WIDTH-1:0] dout, ram_q;
  logic                  full, empty;
  logic                  acc_enq, acc_deq;
  logic                  rd_en, pf_load, we;

  // accept decisions, read issue, next counts
  always_comb begin
    full    = (usedw == DEPTH_C);
    empty   = SA ? !pf_valid : (usedw == '0);
    acc_enq = ch.i_enq & !full;
    acc_deq = ch.i_deq & !empty;
    pf_load = SA ? (q_valid & (!pf_valid | acc_deq))
                 : q_valid;
    rd_en   = SA ? ((ram_cnt != '0) &
                    (!q_valid | pf_load))
                 : acc_deq;
    q_valid_n  = rd_en | (q_valid & !pf_load);
    pf_valid_n = SA & (pf_load | (pf_valid & !acc_deq));
    usedw_n    = usedw + cnt_t'(acc_enq)
                       - cnt_t'(acc_deq);
    ram_cnt_n  = ram_cnt + cnt_t'(acc_enq)
                         - cnt_t'(rd_en);
    we         = acc_enq & !reset;
  end

  li_fifo_ram #(
    .DW       (DATA_WIDTH),
    .AW       (FIFO_ADDR),
    .RAMSTYLE (RAMSTYLE)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (ch.i_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // pointers, counts, pipeline valids, sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw    <= '0;
      ram_cnt  <= '0;
      q_valid  <= 1'b0;
      pf_valid <= 1'b0;
      dout     <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      if (acc_enq) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)   rd_ptr <= rd_ptr + 1'b1;
      usedw    <= usedw_n;
      ram_cnt  <= ram_cnt_n;
      q_valid  <= q_valid_n;
      pf_valid <= pf_valid_n;
      if (pf_load)             dout <= ram_q;
      if (ch.i_enq & full)     ovf  <= 1'b1;
      if (ch.i_deq & empty)    unf  <= 1'b1;
    end
  end

  assign ch.o_data        = dout;
  assign ch.o_empty       = empty;
  assign ch.o_full        = full;
  assign ch.o_almost_full = (usedw >= AF_C);
  assign ch.o_usedw       = usedw;
  assign ch.o_overflow    = ovf;
  assign ch.o_underflow   = unf;

endmodule

// File: tb/tb_li_fifo.sv
// tb_li_fifo: directed vectors for li_fifo.
// Show-ahead and normal instances side by side.
module tb_li_fifo;
  import li_fifo_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  li_fifo_if #(.DATA_WIDTH(16), .FIFO_ADDR(3)) ifa ();
  li_fifo_if #(.DATA_WIDTH(16), .FIFO_ADDR(3)) ifb ();

  li_fifo #(
    .DATA_WIDTH(16), .FIFO_ADDR(3),
    .READY_LATENCY(2), .SHOWAHEAD(SHOWAHEAD_ON),
    .RAMSTYLE("MLAB")
  ) dut_a (
    .clock(clock), .reset(reset), .ch(ifa.slave)
  );

  li_fifo #(
    .DATA_WIDTH(16), .FIFO_ADDR(3),
    .READY_LATENCY(2), .SHOWAHEAD(SHOWAHEAD_OFF),
    .RAMSTYLE("M20K")
  ) dut_b (
    .clock(clock), .reset(reset), .ch(ifb.slave)
  );

  typedef struct {
    bit          enq;
    bit          deq;
    logic [15:0] din;
    bit          e_empty;
    bit          e_full;
    bit          e_af;
    int          e_usedw;
    bit          e_ovf;
    bit          e_unf;
    bit          chk_d;
    logic [15:0] e_data;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(
    bit enq, bit deq, logic [15:0] din,
    bit em, bit fu, bit af, int uw,
    bit ov, bit un, bit cd, logic [15:0] dat
  );
    vec_t v;
    v.enq = enq; v.deq = deq; v.din = din;
    v.e_empty = em; v.e_full = fu; v.e_af = af;
    v.e_usedw = uw; v.e_ovf = ov; v.e_unf = un;
    v.chk_d = cd; v.e_data = dat;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(bit b, bit enq, bit deq,
                     logic [15:0] din);
    if (b) begin
      ifb.i_enq = enq; ifb.i_deq = deq;
      ifb.i_data = din;
    end else begin
      ifa.i_enq = enq; ifa.i_deq = deq;
      ifa.i_data = din;
    end
  endtask

  task automatic check(bit b, vec_t v, string t);
    logic        em, fu, af, ov, un;
    logic [3:0]  uw;
    logic [15:0] d;
    if (b) begin
      em = ifb.o_empty; fu = ifb.o_full;
      af = ifb.o_almost_full; uw = ifb.o_usedw;
      ov = ifb.o_overflow; un = ifb.o_underflow;
      d = ifb.o_data;
    end else begin
      em = ifa.o_empty; fu = ifa.o_full;
      af = ifa.o_almost_full; uw = ifa.o_usedw;
      ov = ifa.o_overflow; un = ifa.o_underflow;
      d = ifa.o_data;
    end
    chk({t, ".empty"}, int'(em), int'(v.e_empty));
    chk({t, ".full"}, int'(fu), int'(v.e_full));
    chk({t, ".afull"}, int'(af), int'(v.e_af));
    chk({t, ".usedw"}, int'(uw), v.e_usedw);
    chk({t, ".ovf"}, int'(ov), int'(v.e_ovf));
    chk({t, ".unf"}, int'(un), int'(v.e_unf));
    if (v.chk_d)
      chk({t, ".data"}, int'(d), int'(v.e_data));
  endtask

  vec_t ta[22];
  vec_t tb[8];
  vec_t rv;
  logic [15:0] mq[$];
  logic [15:0] dd;

  initial begin
    // show-ahead: fill, overflow, drain, underflow
    ta[0]  = mk(1,0,16'h0001, 1,0,0,1, 0,0, 0,16'h0);
    ta[1]  = mk(1,0,16'h0002, 1,0,0,2, 0,0, 0,16'h0);
    ta[2]  = mk(1,0,16'h0003, 0,0,0,3, 0,0, 1,16'h1);
    ta[3]  = mk(1,0,16'h0004, 0,0,0,4, 0,0, 1,16'h1);
    ta[4]  = mk(1,0,16'h0005, 0,0,0,5, 0,0, 1,16'h1);
    ta[5]  = mk(1,0,16'h0006, 0,0,1,6, 0,0, 1,16'h1);
    ta[6]  = mk(1,0,16'h0007, 0,0,1,7, 0,0, 1,16'h1);
    ta[7]  = mk(1,0,16'h0008, 0,1,1,8, 0,0, 1,16'h1);
    ta[8]  = mk(1,0,16'h0BAD, 0,1,1,8, 1,0, 1,16'h1);
    ta[9]  = mk(1,1,16'h0BAD, 0,0,1,7, 1,0, 1,16'h2);
    ta[10] = mk(0,1,16'h0000, 0,0,1,6, 1,0, 1,16'h3);
    ta[11] = mk(0,1,16'h0000, 0,0,0,5, 1,0, 1,16'h4);
    ta[12] = mk(0,1,16'h0000, 0,0,0,4, 1,0, 1,16'h5);
    ta[13] = mk(0,1,16'h0000, 0,0,0,3, 1,0, 1,16'h6);
    ta[14] = mk(0,1,16'h0000, 0,0,0,2, 1,0, 1,16'h7);
    ta[15] = mk(0,1,16'h0000, 0,0,0,1, 1,0, 1,16'h8);
    ta[16] = mk(0,1,16'h0000, 1,0,0,0, 1,0, 0,16'h0);
    ta[17] = mk(0,1,16'h0000, 1,0,0,0, 1,1, 0,16'h0);
    ta[18] = mk(1,1,16'h0042, 1,0,0,1, 1,1, 0,16'h0);
    ta[19] = mk(0,0,16'h0000, 1,0,0,1, 1,1, 0,16'h0);
    ta[20] = mk(0,0,16'h0000, 0,0,0,1, 1,1, 1,16'h42);
    ta[21] = mk(0,1,16'h0000, 1,0,0,0, 1,1, 0,16'h0);
    // normal mode: registered read one edge after pop
    tb[0] = mk(1,0,16'h0011, 0,0,0,1, 0,0, 1,16'h0);
    tb[1] = mk(1,0,16'h0022, 0,0,0,2, 0,0, 1,16'h0);
    tb[2] = mk(0,1,16'h0000, 0,0,0,1, 0,0, 1,16'h0);
    tb[3] = mk(0,0,16'h0000, 0,0,0,1, 0,0, 1,16'h11);
    tb[4] = mk(0,0,16'h0000, 0,0,0,1, 0,0, 1,16'h11);
    tb[5] = mk(0,1,16'h0000, 1,0,0,0, 0,0, 1,16'h11);
    tb[6] = mk(0,0,16'h0000, 1,0,0,0, 0,0, 1,16'h22);
    tb[7] = mk(0,1,16'h0000, 1,0,0,0, 0,1, 1,16'h22);

    rv = mk(0,0,16'h0, 1,0,0,0, 0,0, 1,16'h0);

    drv(0, 0, 0, '0);
    drv(1, 0, 0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check(0, rv, "rst_a");
    check(1, rv, "rst_b");

    foreach (ta[i]) begin
      drv(0, ta[i].enq, ta[i].deq, ta[i].din);
      step();
      check(0, ta[i], $sformatf("sa%0d", i));
    end

    // steady enq+deq at depth 4, pointers wrap
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 16'h0100 + 16'(i));
      mq.push_back(16'h0100 + 16'(i));
      step();
    end
    drv(0, 0, 0, '0);
    step();
    step();
    dd = ifa.o_data;
    chk("wrap.pre.data", int'(dd), int'(mq[0]));
    chk("wrap.pre.usedw", int'(ifa.o_usedw), 4);
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 1, 16'h0104 + 16'(i));
      mq.push_back(16'h0104 + 16'(i));
      void'(mq.pop_front());
      step();
      dd = ifa.o_data;
      chk($sformatf("wrap%0d.usedw", i),
          int'(ifa.o_usedw), 4);
      chk($sformatf("wrap%0d.data", i),
          int'(dd), int'(mq[0]));
    end

    // reset with contents and sticky flags
    drv(0, 1, 0, 16'h01FF);
    step();
    drv(0, 0, 0, '0);
    chk("prerst.usedw", int'(ifa.o_usedw), 5);
    chk("prerst.ovf", int'(ifa.o_overflow), 1);
    chk("prerst.unf", int'(ifa.o_underflow), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check(0, rv, "rst2_a");
    drv(0, 1, 0, 16'h0077);
    step();
    drv(0, 0, 0, '0);
    step();
    step();
    dd = ifa.o_data;
    chk("post.empty", int'(ifa.o_empty), 0);
    chk("post.data", int'(dd), 16'h0077);
    chk("post.usedw", int'(ifa.o_usedw), 1);

    foreach (tb[i]) begin
      drv(1, tb[i].enq, tb[i].deq, tb[i].din);
      step();
      check(1, tb[i], $sformatf("nm%0d", i));
    end
    drv(1, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
